// File: rtl/edh_axi_pkg.sv
// Shared AXI constants, FSM state type and attribute check for the EDH AXI slave memory.
package edh_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_16B    = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_DATA  = 2'd2,
        WR_RESP  = 2'd3
    } axi_slv_state_e;

    // Only full-width INCR bursts are served.
    function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_16B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/edh_axi_sram.sv
// 1R1W word array; the read port is registered, so data appears the cycle after raddr.
module edh_axi_sram #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/edh_axi_slave_mem.sv
// AXI4 slave memory responder: serves one INCR read or write burst at a time from an on-chip array.
module edh_axi_slave_mem
    import edh_axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   awid_s_inf,
    input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
    input  logic [7:0]            awlen_s_inf,
    input  logic [2:0]            awsize_s_inf,
    input  logic [1:0]            awburst_s_inf,
    input  logic                  awvalid_s_inf,
    output logic                  awready_s_inf,
    input  logic [DATA_WIDTH-1:0] wdata_s_inf,
    input  logic                  wlast_s_inf,
    input  logic                  wvalid_s_inf,
    output logic                  wready_s_inf,
    output logic [ID_WIDTH-1:0]   bid_s_inf,
    output logic [1:0]            bresp_s_inf,
    output logic                  bvalid_s_inf,
    input  logic                  bready_s_inf,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [7:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf
);

    // One spare bit so base index + len never wraps and out-of-range beats stay detectable.
    localparam int IDX_W = ADDR_WIDTH + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    axi_slv_state_e      state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          beat_q, beat_d;
    logic [7:0]          len_q, len_d;
    logic                attr_err_q, attr_err_d;
    logic                range_err_q, range_err_d;
    logic                mismatch_q, mismatch_d;

    logic [IDX_W-1:0]      ar_idx, aw_idx;
    logic                  ar_hs, aw_hs, w_hs, r_hs;
    logic                  last_beat, idx_in_range, beat_err, sram_we;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign ar_idx = {1'b0, araddr_s_inf >> 4};
    assign aw_idx = {1'b0, awaddr_s_inf >> 4};

    assign arready_s_inf = !rst && (state_q == IDLE);
    assign awready_s_inf = !rst && (state_q == IDLE) && !arvalid_s_inf;
    assign wready_s_inf  = !rst && (state_q == WR_DATA);
    assign rvalid_s_inf  = (state_q == RD_BURST);
    assign bvalid_s_inf  = (state_q == WR_RESP);

    assign ar_hs = arvalid_s_inf && arready_s_inf;
    assign aw_hs = awvalid_s_inf && awready_s_inf;
    assign w_hs  = wvalid_s_inf && wready_s_inf;
    assign r_hs  = rvalid_s_inf && rready_s_inf;

    assign last_beat    = (beat_q == len_q);
    assign idx_in_range = (idx_q < DEPTH_IDX);
    assign beat_err     = attr_err_q || !idx_in_range;
    assign sram_we      = w_hs && idx_in_range;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        idx_d       = idx_q;
        beat_d      = beat_q;
        len_d       = len_q;
        attr_err_d  = attr_err_q;
        range_err_d = range_err_q;
        mismatch_d  = mismatch_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d        = arid_s_inf;
                    idx_d       = ar_idx;
                    len_d       = arlen_s_inf;
                    beat_d      = 8'd0;
                    attr_err_d  = bad_attr(arsize_s_inf, arburst_s_inf);
                    range_err_d = (ar_idx + IDX_W'(arlen_s_inf)) >= DEPTH_IDX;
                    mismatch_d  = 1'b0;
                    state_d     = RD_BURST;
                end else if (aw_hs) begin
                    id_d        = awid_s_inf;
                    idx_d       = aw_idx;
                    len_d       = awlen_s_inf;
                    beat_d      = 8'd0;
                    attr_err_d  = bad_attr(awsize_s_inf, awburst_s_inf);
                    range_err_d = (aw_idx + IDX_W'(awlen_s_inf)) >= DEPTH_IDX;
                    mismatch_d  = 1'b0;
                    state_d     = WR_DATA;
                end
            end
            RD_BURST: begin
                if (r_hs) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    // Burst length follows awlen; a disagreeing wlast only poisons the response.
                    if (wlast_s_inf != last_beat) begin
                        mismatch_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            WR_RESP: begin
                if (bready_s_inf) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q        <= id_d;
        idx_q       <= idx_d;
        beat_q      <= beat_d;
        len_q       <= len_d;
        attr_err_q  <= attr_err_d;
        range_err_q <= range_err_d;
        mismatch_q  <= mismatch_d;
    end

    // Reading idx_d makes the next beat's word arrive exactly when its beat is presented.
    edh_axi_sram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (wdata_s_inf),
        .raddr (idx_d[AW-1:0]),
        .rdata (sram_rdata)
    );

    assign rid_s_inf   = rvalid_s_inf ? id_q : '0;
    assign rdata_s_inf = (rvalid_s_inf && !beat_err) ? sram_rdata : '0;
    assign rresp_s_inf = (rvalid_s_inf && beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_s_inf = rvalid_s_inf && last_beat;
    assign bid_s_inf   = bvalid_s_inf ? id_q : '0;
    assign bresp_s_inf = (bvalid_s_inf && (attr_err_q || range_err_q || mismatch_q)) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_edh_axi_slave_mem.sv
// Bench for edh_axi_slave_mem: randomized bursts checked against a word-array reference model.
module tb_edh_axi_slave_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   awid, arid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [127:0] wdata, rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] mem_m [256];
    logic [127:0] wbuf  [256];
    logic [127:0] exp_d [256];
    logic [1:0]   exp_r [256];
    logic [127:0] rd_data [256];
    logic [1:0]   rd_resp [256];
    logic         rd_last [256];
    logic [3:0]   rd_id   [256];
    int           rd_beats, rd_lat, rd_viol, rd_arw;
    logic         rd_after;
    bit           rd_to, wr_to;
    logic [3:0]   b_id;
    logic [1:0]   b_resp;

    always #5 clk = ~clk;

    edh_axi_slave_mem dut (
        .clk(clk), .rst(rst),
        .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awlen_s_inf(awlen), .awsize_s_inf(awsize),
        .awburst_s_inf(awburst), .awvalid_s_inf(awvalid), .awready_s_inf(awready),
        .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
        .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
        .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
        .rvalid_s_inf(rvalid), .rready_s_inf(rready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: a plain word array, 16-byte words, no wrap, DEPTH 256.
    task automatic model_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input int wlast_at, output logic [1:0] resp);
        int base;
        bit err;
        base = int'(addr >> 4);
        err  = (size != 3'b100) || (burst != 2'b01) || (base + len > 255) || (wlast_at != len);
        for (int b = 0; b <= len; b++) begin
            int w;
            w = base + b;
            if (w < 256) mem_m[w[7:0]] = wbuf[b[7:0]];
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic model_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst);
        int base;
        bit bad;
        base = int'(addr >> 4);
        bad  = (size != 3'b100) || (burst != 2'b01);
        for (int b = 0; b <= len; b++) begin
            int w;
            w = base + b;
            if (bad || w >= 256) begin
                exp_d[b[7:0]] = '0;
                exp_r[b[7:0]] = 2'b10;
            end else begin
                exp_d[b[7:0]] = mem_m[w[7:0]];
                exp_r[b[7:0]] = 2'b00;
            end
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
        int n;
        wr_to = 0;
        awid = id; awaddr = addr; awlen = len[7:0]; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin tick(); n++; end
        if (n >= 100) wr_to = 1;
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wdata = wbuf[b[7:0]]; wlast = (b == wlast_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin tick(); n++; end
            if (n >= 100) wr_to = 1;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin tick(); n++; end
        if (n >= 100) wr_to = 1;
        b_id = bid; b_resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] rr_pat);
        int cyc;
        logic [127:0] hd;
        logic [1:0] hr;
        logic hl, held;
        rd_to = 0; rd_beats = 0; rd_viol = 0; held = 1'b0; rready = 1'b0;
        arid = id; araddr = addr; arlen = len[7:0]; arsize = size; arburst = burst; arvalid = 1'b1;
        rd_arw = 0;
        while (!arready && rd_arw < 100) begin tick(); rd_arw++; end
        if (rd_arw >= 100) rd_to = 1;
        tick();
        arvalid = 1'b0;
        rd_lat = 1;
        while (!rvalid && rd_lat < 50) begin tick(); rd_lat++; end
        cyc = 0;
        while (rd_beats <= len && cyc < 1000) begin
            rready = rr_pat[cyc[4:0]];
            if (rvalid) begin
                if (held && (rdata !== hd || rresp !== hr || rlast !== hl)) rd_viol++;
                if (rready) begin
                    rd_data[rd_beats[7:0]] = rdata;
                    rd_resp[rd_beats[7:0]] = rresp;
                    rd_last[rd_beats[7:0]] = rlast;
                    rd_id[rd_beats[7:0]]   = rid;
                    rd_beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = rdata; hr = rresp; hl = rlast;
                end
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        rd_after = rvalid;
        if (cyc >= 1000) rd_to = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'b100; awburst = 2'b01; wdata = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'b100; arburst = 2'b01;
        tick(); tick();
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b expected 000000", {arready, awready, wready, rvalid, bvalid, rlast});
        end
        n_checks++;
        if (rdata !== 128'd0 || rid !== 4'd0 || bid !== 4'd0 || rresp !== 2'd0 || bresp !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h rid=%h bid=%h rresp=%h bresp=%h expected all 0", rdata, rid, bid, rresp, bresp);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got arready=%b awready=%b expected 1 1", arready, awready);
        end
    endtask

    task automatic test_fill();
        logic [1:0] er;
        for (int g = 0; g < 16; g++) begin
            for (int b = 0; b < 16; b++) wbuf[b] = rand128();
            do_write(g[3:0], 32'(g * 256), 15, 3'b100, 2'b01, 15);
            model_write(32'(g * 256), 15, 3'b100, 2'b01, 15, er);
            n_checks++;
            if (wr_to || b_resp !== er || b_id !== g[3:0]) begin
                n_fail++;
                $display("FAIL fill_b%0d: got to=%0d bresp=%h bid=%h expected 0 %h %h", g, wr_to, b_resp, b_id, er, g[3:0]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [1:0] er;
        logic [3:0] wid, rdid;
        wid = 4'($urandom); rdid = 4'($urandom);
        for (int b = 0; b < 4; b++) wbuf[b] = rand128();
        do_write(wid, 32'h0000_0100, 3, 3'b100, 2'b01, 3);
        model_write(32'h100, 3, 3'b100, 2'b01, 3, er);
        n_checks++;
        if (wr_to || b_resp !== 2'b00 || b_id !== wid) begin
            n_fail++;
            $display("FAIL wr_b: got to=%0d bresp=%h bid=%h expected 0 00 %h", wr_to, b_resp, b_id, wid);
        end
        model_read(32'h100, 3, 3'b100, 2'b01);
        do_read(rdid, 32'h100, 3, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_to || rd_lat !== 1 || rd_beats !== 4 || rd_after !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_shape: got to=%0d lat=%0d beats=%0d extra=%b expected 0 1 4 0", rd_to, rd_lat, rd_beats, rd_after);
        end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== exp_d[b] || rd_resp[b] !== exp_r[b] || rd_last[b] !== (b == 3) || rd_id[b] !== rdid) begin
                n_fail++;
                $display("FAIL rd_beat%0d: got %h/%h/%b/%h expected %h/%h/%b/%h", b, rd_data[b], rd_resp[b],
                         rd_last[b], rd_id[b], exp_d[b], exp_r[b], (b == 3), rdid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        a = 32'(($urandom % 248) * 16);
        model_read(a, 7, 3'b100, 2'b01);
        do_read(4'h5, a, 7, 3'b100, 2'b01, 32'h9999_9999);
        n_checks++;
        if (rd_to || rd_viol !== 0 || rd_beats !== 8 || rd_after !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_shape: got to=%0d unstable=%0d beats=%0d extra=%b expected 0 0 8 0", rd_to, rd_viol, rd_beats, rd_after);
        end
        for (int b = 0; b < 8; b++) begin
            n_checks++;
            if (rd_data[b] !== exp_d[b] || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 7)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h/%h/%b expected %h/00/%b", b, rd_data[b], rd_resp[b], rd_last[b], exp_d[b], (b == 7));
            end
        end
    endtask

    task automatic test_tie();
        logic [1:0] er;
        arid = 4'h3; araddr = 32'h200; arlen = 8'd1; arsize = 3'b100; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'hC; awaddr = 32'h300; awlen = 8'd0; awsize = 3'b100; awburst = 2'b01; awvalid = 1'b1;
        #1;
        n_checks++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_ready: got arready=%b awready=%b expected 1 0", arready, awready);
        end
        model_read(32'h200, 1, 3'b100, 2'b01);
        do_read(4'h3, 32'h200, 1, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_to || rd_beats !== 2 || rd_data[0] !== exp_d[0] || rd_data[1] !== exp_d[1] || rd_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_read: got beats=%0d d0=%h d1=%h expected 2 %h %h", rd_beats, rd_data[0], rd_data[1], exp_d[0], exp_d[1]);
        end
        n_checks++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_aw_pending: got awready=%b expected 1", awready);
        end
        wbuf[0] = rand128();
        do_write(4'hC, 32'h300, 0, 3'b100, 2'b01, 0);
        model_write(32'h300, 0, 3'b100, 2'b01, 0, er);
        n_checks++;
        if (wr_to || b_resp !== er || b_id !== 4'hC) begin
            n_fail++;
            $display("FAIL tie_write: got to=%0d bresp=%h bid=%h expected 0 %h c", wr_to, b_resp, b_id, er);
        end
        model_read(32'h300, 0, 3'b100, 2'b01);
        do_read(4'h1, 32'h300, 0, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== exp_d[0] || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_raw: got %h/%b/%h expected %h/1/00", rd_data[0], rd_last[0], rd_resp[0], exp_d[0]);
        end
    endtask

    task automatic test_range_edge();
        logic [1:0] er;
        wbuf[0] = rand128(); wbuf[1] = rand128();
        do_write(4'h7, 32'hFF0, 1, 3'b100, 2'b01, 1);
        model_write(32'hFF0, 1, 3'b100, 2'b01, 1, er);
        n_checks++;
        if (wr_to || b_resp !== 2'b10) begin
            n_fail++;
            $display("FAIL edge_bresp: got to=%0d bresp=%h expected 0 10", wr_to, b_resp);
        end
        model_read(32'hFF0, 1, 3'b100, 2'b01);
        do_read(4'h8, 32'hFF0, 1, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== wbuf[0] || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_beat0: got %h/%h/%b expected %h/00/0", rd_data[0], rd_resp[0], rd_last[0], wbuf[0]);
        end
        n_checks++;
        if (rd_data[1] !== 128'd0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1 || rd_beats !== 2) begin
            n_fail++;
            $display("FAIL edge_beat1: got %h/%h/%b beats=%0d expected 0/10/1 2", rd_data[1], rd_resp[1], rd_last[1], rd_beats);
        end
    endtask

    task automatic test_protocol_err();
        logic [1:0] er;
        do_read(4'h2, 32'h500, 3, 3'b100, 2'b10, 32'hFFFF_FFFF);
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== 128'd0 || rd_resp[b] !== 2'b10 || rd_last[b] !== (b == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got %h/%h/%b expected 0/10/%b", b, rd_data[b], rd_resp[b], rd_last[b], (b == 3));
            end
        end
        do_read(4'h2, 32'h500, 0, 3'b011, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== 128'd0 || rd_resp[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL size_err: got %h/%h expected 0/10", rd_data[0], rd_resp[0]);
        end
        for (int b = 0; b < 3; b++) wbuf[b] = rand128();
        do_write(4'h9, 32'h400, 2, 3'b100, 2'b01, 1);
        model_write(32'h400, 2, 3'b100, 2'b01, 1, er);
        n_checks++;
        if (wr_to || b_resp !== 2'b10 || b_id !== 4'h9) begin
            n_fail++;
            $display("FAIL wlast_err: got to=%0d bresp=%h bid=%h expected 0 10 9", wr_to, b_resp, b_id);
        end
        model_read(32'h400, 2, 3'b100, 2'b01);
        do_read(4'h9, 32'h400, 2, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== exp_d[0] || rd_data[1] !== exp_d[1] || rd_data[2] !== exp_d[2]) begin
            n_fail++;
            $display("FAIL wlast_data: got %h %h %h expected %h %h %h", rd_data[0], rd_data[1], rd_data[2], exp_d[0], exp_d[1], exp_d[2]);
        end
    endtask

    task automatic test_reset_midburst();
        arid = 4'h4; araddr = 32'h100; arlen = 8'd3; arsize = 3'b100; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_start: got rvalid=%b expected 1", rvalid);
        end
        tick();
        tick();
        rst = 1'b1; rready = 1'b0;
        tick();
        n_checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || rdata !== 128'd0) begin
            n_fail++;
            $display("FAIL mid_abort: got rvalid=%b bvalid=%b rdata=%h expected 0 0 0", rvalid, bvalid, rdata);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_idle: got arready=%b expected 1", arready);
        end
        model_read(32'h100, 3, 3'b100, 2'b01);
        do_read(4'h6, 32'h100, 3, 3'b100, 2'b01, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_to || rd_arw !== 0 || rd_beats !== 4 || rd_data[3] !== exp_d[3] || rd_last[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reissue: got to=%0d wait=%0d beats=%0d d3=%h expected 0 0 4 %h", rd_to, rd_arw, rd_beats, rd_data[3], exp_d[3]);
        end
    endtask

    task automatic test_random();
        logic [1:0] er;
        for (int t = 0; t < 24; t++) begin
            int w, len;
            logic [3:0] id;
            logic [31:0] a;
            w   = ($urandom % 4 == 0) ? 250 + int'($urandom % 6) : int'($urandom % 256);
            len = int'($urandom % 8);
            id  = 4'($urandom);
            a   = 32'(w * 16) | 32'($urandom % 16);
            if ($urandom % 2 == 0) begin
                for (int b = 0; b <= len; b++) wbuf[b] = rand128();
                do_write(id, a, len, 3'b100, 2'b01, len);
                model_write(a, len, 3'b100, 2'b01, len, er);
                n_checks++;
                if (wr_to || b_resp !== er || b_id !== id) begin
                    n_fail++;
                    $display("FAIL rnd%0d_b: got to=%0d bresp=%h bid=%h expected 0 %h %h", t, wr_to, b_resp, b_id, er, id);
                end
            end else begin
                model_read(a, len, 3'b100, 2'b01);
                do_read(id, a, len, 3'b100, 2'b01, $urandom | 32'h1);
                n_checks++;
                if (rd_to || rd_viol !== 0 || rd_beats !== len + 1 || rd_after !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_shape: got to=%0d unstable=%0d beats=%0d extra=%b", t, rd_to, rd_viol, rd_beats, rd_after);
                end
                for (int b = 0; b <= len; b++) begin
                    n_checks++;
                    if (rd_data[b] !== exp_d[b] || rd_resp[b] !== exp_r[b] || rd_last[b] !== (b == len) || rd_id[b] !== id) begin
                        n_fail++;
                        $display("FAIL rnd%0d_beat%0d: got %h/%h/%b/%h expected %h/%h/%b/%h", t, b, rd_data[b], rd_resp[b],
                                 rd_last[b], rd_id[b], exp_d[b], exp_r[b], (b == len), id);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_backpressure();
        test_tie();
        test_range_edge();
        test_protocol_err();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
